// File: rtl/cnn_acc_pkg.sv
// cnn_acc_pkg: shared state encoding and default widths for the conv1 accumulator
package cnn_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;
  localparam int PROD_W_DEF = 21;
  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 14;
  localparam int KLEN_DEF = 25;
  localparam int SHIFT_DEF = 6;
endpackage

// File: rtl/cnn_conv1_acc_if.sv
// cnn_conv1_acc_if: product/bias input stream and requantized output stream
interface cnn_conv1_acc_if import cnn_acc_pkg::*; #(
  parameter int PROD_W = PROD_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic signed [PROD_W-1:0] prod_din;
  logic prod_vld;
  logic prod_rdy;
  logic signed [OUT_W-1:0] bias_din;
  logic signed [OUT_W-1:0] dout;
  logic dout_vld;
  logic dout_rdy;
  modport master (output prod_din, prod_vld, bias_din, dout_rdy, input prod_rdy, dout, dout_vld);
  modport slave (input prod_din, prod_vld, bias_din, dout_rdy, output prod_rdy, dout, dout_vld);
endinterface

// File: rtl/cnn_conv1_acc_sat.sv
// cnn_conv1_acc_sat: round-half-up requantization with saturation.
// Negative results are clamped to zero when CNN_ACC_RELU_EN is defined.
module cnn_conv1_acc_sat import cnn_acc_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] dout_o
);
  logic signed [ACC_W:0] shr;
  logic signed [OUT_W-1:0] sat;
  logic ovf;
  // one guard bit keeps the rounding add from wrapping at the top of the range
  assign shr = $signed({acc_i[ACC_W-1], acc_i} + ({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1))) >>> SHIFT;
  assign ovf = !(&shr[ACC_W:OUT_W-1] || !(|shr[ACC_W:OUT_W-1]));
  assign sat = ovf ? {shr[ACC_W], {(OUT_W-1){~shr[ACC_W]}}} : shr[OUT_W-1:0];
`ifdef CNN_ACC_RELU_EN
  assign dout_o = sat[OUT_W-1] ? '0 : sat;
`else
  assign dout_o = sat;
`endif
endmodule

// File: rtl/cnn_conv1_acc.sv
// cnn_conv1_acc: accumulates KLEN signed products plus a shifted bias per window and
// emits one requantized activation per window (ReLU option: CNN_ACC_RELU_EN).
module cnn_conv1_acc import cnn_acc_pkg::*; #(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int KLEN = KLEN_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input logic ap_clk,
  input logic ap_rst_n,
  cnn_conv1_acc_if.slave s,
  output logic busy
);
  localparam int CW = KLEN > 1 ? $clog2(KLEN) : 1;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod_x;
  logic signed [OUT_W-1:0] dout_q, sat_w;
  logic vld_q, rdy, accept, last;
  if (PROD_W + $clog2(KLEN) + 1 > ACC_W) begin : g_acc_w_chk
    $error("ACC_W too narrow for KLEN full-scale products");
  end
  assign rdy = state_q != OUT;
  assign busy = state_q != IDLE;
  assign accept = s.prod_vld && rdy;
  assign last = cnt_q == CW'(KLEN - 1);
  assign prod_x = ACC_W'($signed(s.prod_din[PROD_W-1:0]));
  // the first product of a window restarts the sum from the bias, aligned to the product scale
  assign acc_d = state_q == IDLE ? (ACC_W'($signed(s.bias_din[OUT_W-1:0])) <<< SHIFT) + prod_x
                                 : acc_q + prod_x;
  cnn_conv1_acc_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat (
    .acc_i(acc_d),
    .dout_o(sat_w)
  );
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      dout_q <= '0;
      vld_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      state_q <= last ? OUT : ACC;
      if (last) begin
        dout_q <= sat_w;
        vld_q <= 1'b1;
      end
    end else if (state_q == OUT && s.dout_rdy) begin
      state_q <= IDLE;
      vld_q <= 1'b0;
    end
  end
  assign s.prod_rdy = rdy;
  assign s.dout = dout_q;
  assign s.dout_vld = vld_q;
endmodule

// File: tb/tb_cnn_conv1_acc.sv
// tb_cnn_conv1_acc: directed and randomized windows checked against an arithmetic reference
module tb_cnn_conv1_acc;
  import cnn_acc_pkg::*;
  localparam int PW = PROD_W_DEF;
  localparam int OW = OUT_W_DEF;
  localparam int K = KLEN_DEF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int checks = 0;
  int failures = 0;
  int prods[K];
  cnn_conv1_acc_if bus ();
  cnn_conv1_acc dut (.ap_clk(clk), .ap_rst_n(rst_n), .s(bus), .busy(busy));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // floor((bias*2^6 + sum + 32) / 64), clamped to the 14-bit signed range
  function automatic longint model(input int b);
    longint v;
    longint q;
    v = longint'(b) * 64 + 32;
    foreach (prods[i]) v += prods[i];
    q = v / 64;
    if (v % 64 != 0 && v < 0) q--;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
`ifdef CNN_ACC_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic feed(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.prod_vld = 1'b0;
        bus.prod_din = PW'($urandom);
        bus.bias_din = OW'($urandom);
        @(negedge clk);
      end
      chk("no_early_vld", bus.dout_vld, 0);
      chk("prod_rdy_acc", bus.prod_rdy, 1);
      bus.prod_vld = 1'b1;
      bus.prod_din = PW'(prods[i]);
      bus.bias_din = i == 0 ? OW'(b) : OW'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic run_window(input int b, input int hold);
    longint e;
    e = model(b);
    feed(b, K);
    bus.prod_vld = 1'b0;
    bus.prod_din = PW'($urandom);
    chk("dout_vld", bus.dout_vld, 1);
    chk("dout", bus.dout, e);
    chk("prod_rdy_out", bus.prod_rdy, 0);
    chk("busy_out", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", bus.dout_vld, 1);
      chk("hold_dout", bus.dout, e);
      chk("hold_prod_rdy", bus.prod_rdy, 0);
    end
    bus.dout_rdy = 1'b1;
    @(negedge clk);
    chk("release_vld", bus.dout_vld, 0);
    chk("release_prod_rdy", bus.prod_rdy, 1);
    chk("release_busy", busy, 0);
  endtask

  initial begin
    int amp;
    int hold;
    bus.prod_vld = 1'b0;
    bus.prod_din = '0;
    bus.bias_din = '0;
    bus.dout_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dout", bus.dout, 0);
    chk("rst_vld", bus.dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod_rdy", bus.prod_rdy, 1);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (prods[i]) prods[i] = 64;
    run_window(0, 0);
    foreach (prods[i]) prods[i] = i == 0 ? 96 : 0;
    run_window(0, 0);
    foreach (prods[i]) prods[i] = i == 0 ? -96 : 0;
    run_window(0, 0);
    foreach (prods[i]) prods[i] = 1048575;
    run_window(0, 0);
    foreach (prods[i]) prods[i] = -1048576;
    run_window(0, 0);
    foreach (prods[i]) prods[i] = 0;
    run_window(3, 0);
    foreach (prods[i]) prods[i] = int'($urandom_range(0, 8191)) - 4096;
    bus.dout_rdy = 1'b0;
    run_window(int'($urandom_range(0, 255)) - 128, 5);
    foreach (prods[i]) prods[i] = 64;
    feed(0, 10);
    bus.prod_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", bus.dout_vld, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", bus.dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_window(0, 0);
    repeat (20) begin
      amp = 1 << $urandom_range(8, 20);
      foreach (prods[i]) prods[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
      hold = int'($urandom_range(0, 2));
      bus.dout_rdy = hold == 0;
      run_window(int'($urandom_range(0, 16383)) - 8192, hold);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_conv1_acc.md
CNN_CONV1_ACC -- requirements
Module: cnn_conv1_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 21, meaning signed product width from the 7s x 14s multiplier.
REQ-002 SHALL have parameter ACC_W, default 32, meaning internal accumulator width.
REQ-003 SHALL have parameter OUT_W, default 14, meaning signed output activation width.
REQ-004 SHALL have parameter KLEN, default 25, meaning products per output (5x5 kernel).
REQ-005 SHALL have parameter SHIFT, default 6, meaning fractional bits removed at requantization; range 1..ACC_W-OUT_W.
REQ-006 SHALL have port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port prod_din, input, PROD_W, signed product.
REQ-009 SHALL have port prod_vld, input, 1, product valid.
REQ-010 SHALL have port prod_rdy, output, 1, product accepted when prod_vld and prod_rdy are both high.
REQ-011 SHALL have port bias_din, input, OUT_W, signed bias sampled with the first product of each window.
REQ-012 SHALL have port dout, output, OUT_W, signed requantized result.
REQ-013 SHALL have port dout_vld, output, 1, result valid.
REQ-014 SHALL have port dout_rdy, input, 1, downstream accept.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, ACC and OUT: IDLE->ACC on the first accepted product; ACC->OUT on acceptance of product KLEN-1; OUT->IDLE on dout_vld and dout_rdy both high.
REQ-017 SHALL drive prod_rdy high in IDLE and ACC and low in OUT, giving one bubble cycle between windows.
REQ-018 SHALL load acc with sign-extended (bias_din << SHIFT) + prod_din on the first accepted product, and add sign-extended prod_din to acc on each later one.
REQ-019 SHALL count accepted products with cnt, 0..KLEN-1, and clear cnt to 0 on entering OUT.
REQ-020 SHALL compute dout as (acc + 2^(SHIFT-1)) >>> SHIFT (round half up), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 SHALL register dout and assert dout_vld in the cycle after the last product is accepted (latency 1).
REQ-022 SHALL hold dout and dout_vld stable while dout_vld is high and dout_rdy is low.
REQ-023 SHALL size acc so that KLEN full-scale products cannot wrap (PROD_W + clog2(KLEN) + 1 <= ACC_W); acc never wraps.
REQ-024 SHALL ignore prod_din and bias_din whenever prod_vld is low or prod_rdy is low.

Reset
REQ-025 SHALL, while ap_rst_n is low, force state=IDLE, cnt=0, acc=0, dout=0, dout_vld=0 and busy=0 asynchronously.
REQ-026 SHALL discard a partially accumulated window on reset; the first product accepted after reset starts a new window.

Configuration
REQ-027 SHALL use macro CNN_ACC_RELU_EN: when defined, dout is clamped to 0 if the saturated result is negative; when undefined, signed results pass through unchanged.

Structure
REQ-028 SHALL place the state enum, default widths and KLEN/SHIFT constants in the shared package cnn_acc_pkg.
REQ-029 SHALL implement rounding, saturation and optional ReLU in combinational sub-module cnn_conv1_acc_sat.

Verification
REQ-030 SHALL cover: bias 0, 25 products of 64 -> dout=25, dout_vld one cycle after the last accept.
REQ-031 SHALL cover rounding: bias 0, one product 96 and 24 zeros -> dout=2; one product -96 and 24 zeros -> dout=-1.
REQ-032 SHALL cover saturation: bias 0, 25 products of 1048575 -> 8191; 25 products of -1048576 -> -8192, or 0 with CNN_ACC_RELU_EN.
REQ-033 SHALL cover bias: bias 3, 25 zero products -> dout=3.
REQ-034 SHALL cover backpressure: dout_rdy low for 5 cycles -> dout and dout_vld held, prod_rdy low; on release, state=IDLE and prod_rdy=1 next cycle.
REQ-035 SHALL cover reset mid-window: ap_rst_n pulsed low after 10 products -> dout_vld=0, busy=0; next 25 products of 64 -> dout=25.
